// File: rtl/gcd_requester.sv
// gcd_requester: queues operand pairs and runs them through a GCD unit one job at a time; GCD_REQ_TIMEOUT_EN adds a WAIT timeout.
module gcd_requester #(
  parameter int width          = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [width-1:0] job_a,
  input  logic [width-1:0] job_b,
  output logic [width-1:0] operand_A,
  output logic [width-1:0] operand_B,
  output logic             input_ready,
  input  logic             input_available,
  input  logic             result_rdy,
  input  logic [width-1:0] result_data,
  output logic             result_taken,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [width-1:0] res_data,
  output logic             res_err,
  output logic             busy,
  output logic [15:0]      job_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] FULL = FW'(FIFO_DEPTH);
  typedef enum logic [2:0] {FLUSH, IDLE, ISSUE, WAIT, TAKE, OUT} state_t;
  state_t state, state_n;
  logic [width-1:0] mem_a [FIFO_DEPTH];
  logic [width-1:0] mem_b [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] fill, fill_n;
  logic push, pop, timeout, res_err_n;
  logic [width-1:0] res_data_n;
  assign push   = job_valid && job_ready;
  assign pop    = state == IDLE && fill != '0;
  assign fill_n = fill + FW'(push) - FW'(pop);
`ifdef GCD_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) tmo_cnt <= '0;
    else tmo_cnt <= state == WAIT ? tmo_cnt + 1'b1 : '0;
  assign timeout = state == WAIT && !result_rdy && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge sys_clk)
    if (push) begin
      mem_a[wr_ptr] <= job_a;
      mem_b[wr_ptr] <= job_b;
    end
  always_comb begin
    state_n    = state;
    res_data_n = res_data;
    res_err_n  = res_err;
    unique case (state)
      FLUSH: state_n = !result_rdy && !result_taken && input_available ? IDLE : FLUSH;
      IDLE:  state_n = fill != '0 ? ISSUE : IDLE;
      ISSUE: state_n = input_available ? WAIT : ISSUE;
      WAIT: begin
        state_n    = result_rdy ? TAKE : timeout ? OUT : WAIT;
        res_data_n = result_rdy ? result_data : timeout ? '0 : res_data;
        res_err_n  = timeout;
      end
      TAKE:  state_n = OUT;
      OUT: begin
        state_n   = !res_ready ? OUT : res_err ? FLUSH : IDLE;
        res_err_n = res_err && !res_ready;
      end
      default: state_n = FLUSH;
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state        <= FLUSH;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill         <= '0;
      job_ready    <= 1'b0;
      busy         <= 1'b0;
      operand_A    <= '0;
      operand_B    <= '0;
      input_ready  <= 1'b0;
      result_taken <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_err      <= 1'b0;
      job_count    <= '0;
    end else begin
      state        <= state_n;
      wr_ptr       <= wr_ptr + AW'(push);
      rd_ptr       <= rd_ptr + AW'(pop);
      fill         <= fill_n;
      job_ready    <= fill_n != FULL;
      busy         <= state_n != IDLE || fill_n != '0;
      if (pop) begin
        operand_A <= mem_a[rd_ptr];
        operand_B <= mem_b[rd_ptr];
      end
      input_ready  <= state_n == ISSUE;
      result_taken <= state_n == TAKE || (state == FLUSH && result_rdy && !result_taken);
      res_valid    <= state_n == OUT;
      res_data     <= res_data_n;
      res_err      <= res_err_n;
      if (state == OUT && res_ready) job_count <= job_count + 16'd1;
    end
endmodule

// File: tb/tb_gcd_requester.sv
// tb_gcd_requester: directed checks of gcd_requester against a behavioural GCD unit without reset.
module tb_gcd_requester;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n, job_valid, job_ready, input_ready, result_taken;
  logic       res_valid, res_ready, res_err, busy;
  logic [7:0] job_a, job_b, operand_A, operand_B, res_data;
  logic [15:0] job_count;
  logic       input_available = 1'b0;
  logic       result_rdy = 1'b1;
  logic [7:0] result_data = 8'hAA;
  int         gcd_cnt = 0;
  bit         gcd_hang = 1'b0;
  int checks = 0, failures = 0;
  int pulses = 0, taken_cycles = 0, overlap = 0, valid_cycles = 0;
  logic taken_q = 1'b0;

  gcd_requester #(.width(8), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(15)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_a(job_a), .job_b(job_b), .operand_A(operand_A), .operand_B(operand_B),
    .input_ready(input_ready), .input_available(input_available), .result_rdy(result_rdy),
    .result_data(result_data), .result_taken(result_taken), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_err(res_err), .busy(busy),
    .job_count(job_count)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [7:0] gcd_f(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] t;
    while (b != 0) begin
      t = b;
      b = a % b;
      a = t;
    end
    return a;
  endfunction

  // GCD unit: starts holding a stale result, 3-cycle compute, gcd_hang stalls completion
  always @(posedge sys_clk) begin
    if (result_rdy && result_taken) begin
      result_rdy      <= 1'b0;
      input_available <= 1'b1;
    end else if (input_available && input_ready) begin
      input_available <= 1'b0;
      gcd_cnt         <= 3;
      result_data     <= gcd_f(operand_A, operand_B);
    end else if (!input_available && !result_rdy && !gcd_hang) begin
      if (gcd_cnt == 0) result_rdy <= 1'b1;
      else gcd_cnt <= gcd_cnt - 1;
    end
  end

  always @(posedge sys_clk) begin
    if (result_taken && !taken_q) pulses++;
    if (result_taken) taken_cycles++;
    if (result_taken && input_ready) overlap++;
    if (res_valid) valid_cycles++;
    taken_q = result_taken;
  end

  task automatic push_job(input logic [7:0] a, input logic [7:0] b);
    job_valid = 1'b1;
    job_a = a;
    job_b = b;
    @(negedge sys_clk);
    job_valid = 1'b0;
  endtask

  task automatic test_reset;
    int p0;
    sys_rst_n = 1'b0; job_valid = 1'b0; res_ready = 1'b0; job_a = '0; job_b = '0;
    repeat (2) @(negedge sys_clk);
    checks++;
    if ({job_ready, input_ready, result_taken, res_valid, res_err, busy, operand_A, operand_B, res_data, job_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0", {job_ready, input_ready, result_taken, res_valid, res_err, busy, operand_A, operand_B, res_data, job_count});
    end
    p0 = pulses;
    sys_rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    checks++;
    if (pulses - p0 !== 1) begin failures++; $display("FAIL flush_pulse: got %0d pulses required 1", pulses - p0); end
    checks++;
    if (busy !== 1'b0 || job_ready !== 1'b1) begin failures++; $display("FAIL flush_idle: busy=%b job_ready=%b required 0/1", busy, job_ready); end
    checks++;
    if (valid_cycles !== 0) begin failures++; $display("FAIL flush_no_valid: got %0d required 0", valid_cycles); end
  endtask

  task automatic test_single;
    int p0;
    p0 = pulses;
    res_ready = 1'b1;
    push_job(8'd48, 8'd18);
    for (int i = 0; i < 50 && !input_ready; i++) @(negedge sys_clk);
    checks++;
    if (input_ready !== 1'b1 || operand_A !== 8'd48 || operand_B !== 8'd18) begin
      failures++;
      $display("FAIL single_issue: ir=%b A=%0d B=%0d required 1/48/18", input_ready, operand_A, operand_B);
    end
    for (int i = 0; i < 100 && !res_valid; i++) @(negedge sys_clk);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'd6 || res_err !== 1'b0) begin
      failures++;
      $display("FAIL single_result: valid=%b data=%0d err=%b required 1/6/0", res_valid, res_data, res_err);
    end
    @(negedge sys_clk);
    checks++;
    if (job_count !== 16'd1 || pulses - p0 !== 1) begin
      failures++;
      $display("FAIL single_count: job_count=%0d pulses=%0d required 1/1", job_count, pulses - p0);
    end
  endtask

  task automatic test_hold_out;
    int bad;
    res_ready = 1'b0;
    push_job(8'd9, 8'd6);
    for (int i = 0; i < 100 && !res_valid; i++) @(negedge sys_clk);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'd3) begin failures++; $display("FAIL hold_result: valid=%b data=%0d required 1/3", res_valid, res_data); end
    bad = 0;
    repeat (10) begin
      @(negedge sys_clk);
      if (res_valid !== 1'b1 || res_data !== 8'd3 || input_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL hold_stable: got %0d unstable cycles required 0", bad); end
    checks++;
    if (job_count !== 16'd1) begin failures++; $display("FAIL hold_count: got %0d required 1", job_count); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ja [4] = '{8'd12, 8'd7, 8'd0, 8'd255};
    logic [7:0] jb [4] = '{8'd8, 8'd0, 8'd0, 8'd85};
    logic [7:0] exp [5] = '{8'd3, 8'd4, 8'd7, 8'd0, 8'd85};
    int p0;
    p0 = pulses;
    for (int k = 0; k < 4; k++) push_job(ja[k], jb[k]);
    checks++;
    if (job_ready !== 1'b0) begin failures++; $display("FAIL fifo_full: job_ready=%b required 0", job_ready); end
    checks++;
    if (input_ready !== 1'b0 || res_valid !== 1'b1) begin failures++; $display("FAIL full_no_issue: ir=%b valid=%b required 0/1", input_ready, res_valid); end
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 100 && !res_valid; i++) @(negedge sys_clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== exp[k]) begin
        failures++;
        $display("FAIL b2b_result%0d: valid=%b data=%0d required 1/%0d", k, res_valid, res_data, exp[k]);
      end
      @(negedge sys_clk);
    end
    checks++;
    if (job_count !== 16'd6 || busy !== 1'b0 || pulses - p0 !== 4) begin
      failures++;
      $display("FAIL b2b_done: job_count=%0d busy=%b pulses=%0d required 6/0/4", job_count, busy, pulses - p0);
    end
  endtask

  task automatic test_reset_mid;
    int p0, v0;
    res_ready = 1'b1;
    push_job(8'd20, 8'd15);
    push_job(8'd30, 8'd12);
    for (int i = 0; i < 50 && !input_ready; i++) @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({input_ready, result_taken, res_valid, busy, job_ready} !== 5'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got %b required 00000", {input_ready, result_taken, res_valid, busy, job_ready});
    end
    for (int i = 0; i < 50 && !result_rdy; i++) @(negedge sys_clk);
    @(negedge sys_clk);
    p0 = pulses;
    v0 = valid_cycles;
    sys_rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    checks++;
    if (pulses - p0 !== 1 || valid_cycles - v0 !== 0) begin
      failures++;
      $display("FAIL mid_flush: pulses=%0d valid=%0d required 1/0", pulses - p0, valid_cycles - v0);
    end
    checks++;
    if (busy !== 1'b0 || job_count !== 16'd0) begin failures++; $display("FAIL mid_lost: busy=%b job_count=%0d required 0/0", busy, job_count); end
    push_job(8'd21, 8'd14);
    for (int i = 0; i < 100 && !res_valid; i++) @(negedge sys_clk);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'd7) begin failures++; $display("FAIL mid_next: valid=%b data=%0d required 1/7", res_valid, res_data); end
    @(negedge sys_clk);
    checks++;
    if (job_count !== 16'd1) begin failures++; $display("FAIL mid_count: got %0d required 1", job_count); end
  endtask

`ifdef GCD_REQ_TIMEOUT_EN
  task automatic test_timeout;
    int n, p0;
    gcd_hang = 1'b1;
    res_ready = 1'b1;
    push_job(8'd5, 8'd3);
    for (int i = 0; i < 50 && !input_ready; i++) @(negedge sys_clk);
    n = 0;
    while (!res_valid && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    checks++;
    if (res_valid !== 1'b1 || res_err !== 1'b1 || res_data !== 8'd0 || n !== 16) begin
      failures++;
      $display("FAIL timeout_out: valid=%b err=%b data=%0d cycles=%0d required 1/1/0/16", res_valid, res_err, res_data, n);
    end
    @(negedge sys_clk);
    checks++;
    if (res_err !== 1'b0 || job_count !== 16'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_flush: err=%b job_count=%0d busy=%b required 0/2/1", res_err, job_count, busy);
    end
    p0 = pulses;
    gcd_hang = 1'b0;
    for (int i = 0; i < 50 && busy; i++) @(negedge sys_clk);
    checks++;
    if (busy !== 1'b0 || pulses - p0 !== 1 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_drain: busy=%b pulses=%0d valid=%b required 0/1/0", busy, pulses - p0, res_valid);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_hold_out;
    test_back_to_back;
    test_reset_mid;
`ifdef GCD_REQ_TIMEOUT_EN
    test_timeout;
`endif
    checks++;
    if (overlap !== 0 || taken_cycles !== pulses) begin
      failures++;
      $display("FAIL taken_shape: overlap=%0d taken_cycles=%0d pulses=%0d required 0/equal", overlap, taken_cycles, pulses);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/gcd_requester.md
Name: gcd_requester

Overview:
- Initiator-side driver for the team's GCD unit.
- Buffers operand pairs from an upstream job stream in a small FIFO and issues them one at a time over the GCD operand handshake (operand_A/operand_B, input_ready/input_available).
- Consumes the result over result_rdy/result_taken, then presents it downstream on a valid/ready port.
- Sits between a job source (test harness or host logic) and the GCD unit top level.

Parameters:
- width, 8, operand and result bit width; must match the GCD unit.
- FIFO_DEPTH, 4, job FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 1023, WAIT-state cycle limit; used only with the optional feature.

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- job_valid  in  1  upstream job present.
- job_ready  out  1  FIFO can accept; equals !full.
- job_a  in  width  operand A of the job.
- job_b  in  width  operand B of the job.
- operand_A  out  width  to GCD, registered.
- operand_B  out  width  to GCD, registered.
- input_ready  out  1  operands valid to GCD.
- input_available  in  1  GCD idle and accepting.
- result_rdy  in  1  GCD holds a result.
- result_data  in  width  GCD result.
- result_taken  out  1  one-cycle pulse that consumes the GCD result.
- res_valid  out  1  downstream result valid.
- res_ready  in  1  downstream accepts.
- res_data  out  width  GCD of the job.
- res_err  out  1  result aborted by timeout; tied 0 without the macro.
- busy  out  1  FSM not in IDLE or FIFO not empty.
- job_count  out  16  completed jobs, wraps 0xFFFF to 0.

Behaviour:
Clocking and reset
- One clock domain, sys_clk.
- Reset is asynchronous and active-low (sys_rst_n).
- Reset forces: all outputs 0, FIFO empty, FSM to FLUSH, job_count 0.

Job FIFO
- Push when job_valid && job_ready.
- Pop on the IDLE to ISSUE transition.
- Push and pop in the same cycle are both honoured when not full.
- Push while full is impossible because job_ready=0. Pop while empty never occurs.

FSM
- FLUSH: the GCD unit has no reset and may hold a stale result.
  - result_rdy=1: assert result_taken for exactly one cycle, discard result_data, stay in FLUSH.
  - result_rdy=0 and input_available=1: go to IDLE.
- IDLE: FIFO not empty → load operand_A/operand_B from the head, pop, go to ISSUE.
- ISSUE: input_ready=1 with operands held stable.
  - The transfer happens on the edge where input_ready && input_available.
  - On transfer: drop input_ready next cycle and go to WAIT.
- WAIT: result_rdy=1 → capture result_data into res_data, go to TAKE.
- TAKE: result_taken=1 for exactly this one cycle, then go to OUT.
- OUT: res_valid=1, with res_data held.
  - res_ready=1 at the edge: clear res_valid, increment job_count, go to IDLE.
- Outputs are registered. result_taken and input_ready never assert in the same cycle. Only one job is outstanding at a time.
- Minimum turnaround, excluding GCD compute: IDLE, ISSUE, WAIT, TAKE, OUT = 5 cycles per job with res_ready tied high.

Operand corner cases
- Operands pass unmodified. B=0 yields A; A=B=0 yields 0. The requester does not special-case either.

Reset mid-operation
- Any state returns to FLUSH, input_ready and result_taken drop immediately, the queued FIFO jobs and the in-flight result are lost.
- FLUSH guarantees the GCD unit is drained before the next issue.

Optional Feature:
Macro: GCD_REQ_TIMEOUT_EN

With the macro defined:
- A counter clears on entry to WAIT and increments each WAIT cycle.
- If it reaches TIMEOUT_CYCLES with result_rdy still 0: set res_data=0 and res_err=1, then go to OUT.
- res_err clears when the OUT handshake completes.
- job_count still increments on that handshake.
- After a timeout the next state is FLUSH instead of IDLE, so the late result is discarded.

Without the macro:
- No counter; WAIT waits indefinitely.
- res_err is constant 0.

Test Plan:
- Reset, then push (48,18) with res_ready=1 → input_ready asserts with operand_A=48 and operand_B=18; one result_taken pulse; res_valid with res_data=6, res_err=0; job_count=1.
- Push 4 jobs back-to-back, (12,8) (7,0) (0,0) (255,85), with no result draining → job_ready drops after the 4th push. Results out in order: 4, 7, 0, 85. job_count=4.
- Hold res_ready=0 for 10 cycles in OUT → res_valid and res_data stay stable. No new input_ready until the handshake completes.
- Assert sys_rst_n=0 while in WAIT and release while the GCD model holds result_rdy=1 → a single result_taken pulse in FLUSH, nothing presented on res_valid, then normal operation on the next job.
- With GCD_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=15, the GCD model never raises result_rdy → after 15 WAIT cycles, res_valid=1 with res_err=1 and res_data=0, then FSM goes to FLUSH.
